// File: rtl/coil_rst_pkg.sv
// Shared definitions for the coil-driver reset sequencer: state encoding,
// status-slave address map, status bit positions and a sizing helper.
package coil_rst_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  // Encoding is visible to software through the status word.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_OFF = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } seq_state_e;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CAUSE  = 2'd2;

  localparam int unsigned STAT_FAULT_BIT = 0;
  localparam int unsigned STAT_STATE_LSB = 1;
  localparam int unsigned STAT_BUSY_BIT  = 3;

  localparam int unsigned CAUSE_W = 2;

  // Largest of three timing parameters; sizes the shared down-counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk, reset_n : destination clock and async active-low reset
//   d            : asynchronous input
//   q            : synchronised output (two cycles of latency)
// RST_VAL sets both flops on reset so the output starts at a known safe level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability capture stage followed by the output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coil_reset_sequencer.sv
// Ordered reset sequencer for the coil-driver core: gates off, core reset held,
// core reset released, gates re-enabled after a settling lag. Triggered by the
// software reset level or a synchronised external fault.
//   clk, reset_n          : clock, async active-low reset
//   reset_req             : software reset level (same clock domain)
//   fault_n               : asynchronous active-low fault
//   address/chipselect/read/readdata : combinational read-only status slave
//   gate_disable          : 1 forces the power-stage gates off
//   core_reset_n          : active-low reset to the coil-driver core
//   seq_busy              : 1 whenever the sequencer is not idle
module coil_reset_sequencer
  import coil_rst_pkg::*;
#(
  parameter int unsigned GATE_LEAD   = 16,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned RELEASE_LAG = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reset_req,
  input  logic              fault_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic              gate_disable,
  output logic              core_reset_n,
  output logic              seq_busy
);

  localparam int unsigned TMR_MAX = max3(GATE_LEAD, HOLD_CYCLES, RELEASE_LAG);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_LEAD - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REL_LOAD  = TMR_W'(RELEASE_LAG - 1);

  seq_state_e         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               gate_d, core_d, busy_d;
  logic               fault_sync;
  logic               fault_s;
  logic               trig;

  // Fault input idles high, so the synchroniser resets to "no fault".
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_fault_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (fault_n),
    .q      (fault_sync)
  );

  assign fault_s = ~fault_sync;
  assign trig    = reset_req | fault_s;

  // State register; reset lands in HOLD so power-up runs a full release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      tmr_q        <= HOLD_LOAD;
      count_q      <= '0;
      cause_q      <= '0;
      gate_disable <= 1'b1;
      core_reset_n <= 1'b0;
      seq_busy     <= 1'b1;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      count_q      <= count_d;
      cause_q      <= cause_d;
      gate_disable <= gate_d;
      core_reset_n <= core_d;
      seq_busy     <= busy_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    count_d = count_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_GATE_OFF;
          tmr_d   = GATE_LOAD;
          count_d = count_q + CNT_W'(1);
          cause_d = {fault_s, reset_req};
        end
      end
      ST_GATE_OFF: begin
        if (tmr_q == '0) begin
          state_d = ST_HOLD;
          tmr_d   = HOLD_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_HOLD: begin
        // Timer parks at zero; a still-active trigger keeps the core in reset.
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (!trig) begin
          state_d = ST_RELEASE;
          tmr_d   = REL_LOAD;
        end
      end
      ST_RELEASE: begin
        // Gates are still off, so a new trigger goes straight back to HOLD.
        if (trig) begin
          state_d = ST_HOLD;
          tmr_d   = HOLD_LOAD;
          count_d = count_q + CNT_W'(1);
          cause_d = {fault_s, reset_req};
        end else if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs change on entry.
  always_comb begin
    gate_d = 1'b1;
    core_d = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      ST_IDLE: begin
        gate_d = 1'b0;
        busy_d = 1'b0;
      end
      ST_HOLD: begin
        core_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Zero wait-state status read path; no side effects.
  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        ADDR_STATUS: begin
          readdata[STAT_FAULT_BIT]      = fault_s;
          readdata[STAT_STATE_LSB +: 2] = state_q;
          readdata[STAT_BUSY_BIT]       = seq_busy;
        end
        ADDR_COUNT: readdata = DATA_W'(count_q);
        ADDR_CAUSE: readdata = DATA_W'(cause_q);
        default:    readdata = '0;
      endcase
    end
  end

endmodule
